// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// Digits are 4-bit BCD; the clamp helper limits a preset digit to its legal maximum.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX_9 = 4'd9;
    localparam bcd_t DIGIT_MAX_5 = 4'd5;

    function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Four-digit MM:SS BCD down counter with clamped parallel load.
// Load has priority over the enable; 00:00 is a floor and is never decremented.
module bcd_down_counter
    import timer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    input  bcd_t preset_minutes_tens,
    input  bcd_t preset_minutes_units,
    input  bcd_t preset_seconds_tens,
    input  bcd_t preset_seconds_units,
    output bcd_t minutes_tens,
    output bcd_t minutes_units,
    output bcd_t seconds_tens,
    output bcd_t seconds_units,
    output logic is_zero
);

    assign is_zero = (minutes_tens == 4'd0) && (minutes_units == 4'd0) &&
                     (seconds_tens == 4'd0) && (seconds_units == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            minutes_tens  <= 4'd0;
            minutes_units <= 4'd0;
            seconds_tens  <= 4'd0;
            seconds_units <= 4'd0;
        end else if (load) begin
            minutes_tens  <= clamp_digit(preset_minutes_tens,  DIGIT_MAX_9);
            minutes_units <= clamp_digit(preset_minutes_units, DIGIT_MAX_9);
            seconds_tens  <= clamp_digit(preset_seconds_tens,  DIGIT_MAX_5);
            seconds_units <= clamp_digit(preset_seconds_units, DIGIT_MAX_9);
        end else if (en && !is_zero) begin
            // Borrow ripples upward; a nonzero count guarantees minutes_tens > 0 when reached.
            if (seconds_units != 4'd0) begin
                seconds_units <= seconds_units - 4'd1;
            end else begin
                seconds_units <= DIGIT_MAX_9;
                if (seconds_tens != 4'd0) begin
                    seconds_tens <= seconds_tens - 4'd1;
                end else begin
                    seconds_tens <= DIGIT_MAX_5;
                    if (minutes_units != 4'd0) begin
                        minutes_units <= minutes_units - 4'd1;
                    end else begin
                        minutes_units <= DIGIT_MAX_9;
                        minutes_tens  <= minutes_tens - 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Programmable MM:SS countdown timer: FSM, 1 s prescaler and alarm counter around a BCD down counter.
// All outputs are registered; digit changes appear the cycle after the prescaler tick.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int ALARM_SECONDS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [3:0] preset_minutes_tens,
    input  logic [3:0] preset_minutes_units,
    input  logic [3:0] preset_seconds_tens,
    input  logic [3:0] preset_seconds_units,
    output logic [3:0] minutes_tens,
    output logic [3:0] minutes_units,
    output logic [3:0] seconds_tens,
    output logic [3:0] seconds_units,
    output logic       running,
    output logic       expired,
    output logic       alarm_blink
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int ALARM_W = $clog2(ALARM_SECONDS + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_SECONDS - 1);

    state_t               state;
    logic [PRESC_W-1:0]   presc;
    logic [ALARM_W-1:0]   alarm_cnt;
    logic                 tick;
    logic                 is_zero;
    logic                 at_one;
    logic                 ctr_load;
    logic                 ctr_en;

    assign tick     = ((state == RUN) || (state == EXPIRED)) && (presc == PRESC_LAST);
    assign ctr_load = load && (state != RUN);
    assign ctr_en   = tick && (state == RUN);
    assign at_one   = (minutes_tens == 4'd0) && (minutes_units == 4'd0) &&
                      (seconds_tens == 4'd0) && (seconds_units == 4'd1);

    bcd_down_counter u_counter (
        .clk                  (clk),
        .rst                  (rst),
        .load                 (ctr_load),
        .en                   (ctr_en),
        .preset_minutes_tens  (preset_minutes_tens),
        .preset_minutes_units (preset_minutes_units),
        .preset_seconds_tens  (preset_seconds_tens),
        .preset_seconds_units (preset_seconds_units),
        .minutes_tens         (minutes_tens),
        .minutes_units        (minutes_units),
        .seconds_tens         (seconds_tens),
        .seconds_units        (seconds_units),
        .is_zero              (is_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            presc       <= '0;
            alarm_cnt   <= '0;
            running     <= 1'b0;
            expired     <= 1'b0;
            alarm_blink <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc <= '0;
                    if (!load && start && !is_zero) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    presc <= tick ? '0 : presc + PRESC_W'(1);
                    // Reaching 00:00 on a tick outranks a simultaneous pause.
                    if (tick && at_one) begin
                        state       <= EXPIRED;
                        running     <= 1'b0;
                        expired     <= 1'b1;
                        alarm_cnt   <= '0;
                        alarm_blink <= 1'b0;
                    end else if (pause) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (load) begin
                        state <= IDLE;
                        presc <= '0;
                    end else if (start && !pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                EXPIRED: begin
                    if (load || start || (tick && (alarm_cnt == ALARM_LAST))) begin
                        state       <= IDLE;
                        presc       <= '0;
                        alarm_cnt   <= '0;
                        alarm_blink <= 1'b0;
                        expired     <= 1'b0;
                    end else if (tick) begin
                        presc       <= '0;
                        alarm_cnt   <= alarm_cnt + ALARM_W'(1);
                        alarm_blink <= ~alarm_blink;
                    end else begin
                        presc <= presc + PRESC_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    presc   <= '0;
                    running <= 1'b0;
                    expired <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a seconds-based reference model predicts each cycle's outputs,
// a monitor compares them after every clock edge, plus directed checks of the key scenarios.
module tb_countdown_timer;

    localparam int CLK_HZ        = 10;
    localparam int ALARM_SECONDS = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [3:0] p_mt = 4'd0, p_mu = 4'd0, p_st = 4'd0, p_su = 4'd0;
    logic [3:0] minutes_tens, minutes_units, seconds_tens, seconds_units;
    logic       running, expired, alarm_blink;

    logic [18:0] exp_q[$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;

    // Reference model state: whole count in seconds, phase within the current second.
    int m_mode  = M_IDLE;
    int m_secs  = 0;
    int m_phase = 0;
    int m_alarm = 0;
    bit m_blink = 1'b0;

    countdown_timer #(
        .CLK_HZ        (CLK_HZ),
        .ALARM_SECONDS (ALARM_SECONDS)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .pause                (pause),
        .load                 (load),
        .preset_minutes_tens  (p_mt),
        .preset_minutes_units (p_mu),
        .preset_seconds_tens  (p_st),
        .preset_seconds_units (p_su),
        .minutes_tens         (minutes_tens),
        .minutes_units        (minutes_units),
        .seconds_tens         (seconds_tens),
        .seconds_units        (seconds_units),
        .running              (running),
        .expired              (expired),
        .alarm_blink          (alarm_blink)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] dut_vec();
        return {minutes_tens, minutes_units, seconds_tens, seconds_units,
                running, expired, alarm_blink};
    endfunction

    function automatic logic [18:0] model_vec();
        logic [3:0] mt, mu, st, su;
        mt = 4'(m_secs / 600);
        mu = 4'((m_secs / 60) % 10);
        st = 4'((m_secs % 60) / 10);
        su = 4'(m_secs % 10);
        return {mt, mu, st, su, m_mode == M_RUN, m_mode == M_EXP, m_blink};
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got digits=%h run=%b exp=%b blink=%b, required digits=%h run=%b exp=%b blink=%b",
                      name, got[18:3], got[2], got[1], got[0], want[18:3], want[2], want[1], want[0]);
    endtask

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_alarm = 0; m_blink = 1'b0;
    endtask

    task automatic model_to_idle();
        m_mode = M_IDLE; m_phase = 0; m_alarm = 0; m_blink = 1'b0;
    endtask

    // One clock edge of the timer's rules, applied to the seconds-based model.
    task automatic model_step(input bit s, input bit p, input bit l,
                              input int a, input int b, input int c, input int d);
        bit tk;
        tk = (m_mode == M_RUN || m_mode == M_EXP) && (m_phase == CLK_HZ - 1);
        case (m_mode)
            M_IDLE: begin
                if (l) m_secs = (clampi(a, 9) * 10 + clampi(b, 9)) * 60 + clampi(c, 5) * 10 + clampi(d, 9);
                else if (s && m_secs != 0) begin m_mode = M_RUN; m_phase = 0; end
            end
            M_RUN: begin
                m_phase = tk ? 0 : m_phase + 1;
                if (tk) m_secs = m_secs - 1;
                if (tk && m_secs == 0) begin m_mode = M_EXP; m_alarm = 0; m_blink = 1'b0; end
                else if (p) m_mode = M_PAUSE;
            end
            M_PAUSE: begin
                if (l) begin
                    m_secs = (clampi(a, 9) * 10 + clampi(b, 9)) * 60 + clampi(c, 5) * 10 + clampi(d, 9);
                    model_to_idle();
                end else if (s && !p) m_mode = M_RUN;
            end
            default: begin
                m_phase = tk ? 0 : m_phase + 1;
                if (l) begin
                    m_secs = (clampi(a, 9) * 10 + clampi(b, 9)) * 60 + clampi(c, 5) * 10 + clampi(d, 9);
                    model_to_idle();
                end else if (s) model_to_idle();
                else if (tk) begin
                    m_alarm++;
                    m_blink = ~m_blink;
                    if (m_alarm == ALARM_SECONDS) model_to_idle();
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input bit s, input bit p, input bit l,
                        input int a, input int b, input int c, input int d);
        @(negedge clk);
        start = s; pause = p; load = l;
        p_mt = 4'(a); p_mu = 4'(b); p_st = 4'(c); p_su = 4'(d);
        model_step(s, p, l, a, b, c, d);
        exp_q.push_back(model_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check("model", dut_vec(), exp_q.pop_front());
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b0;
        #1 check("reset", dut_vec(), 19'h0);
        model_reset();
        @(negedge clk) rst = 1'b1;

        // 01:00 counts down to 00:59 after one second, then to expiry.
        step(0, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(10);
        settle();
        check("t1_0059", dut_vec(), {16'h0059, 3'b100});
        idle(590);
        settle();
        check("t1_expired", dut_vec(), {16'h0000, 3'b010});
        idle(30);
        settle();
        check("t1_auto_idle", dut_vec(), 19'h0);

        // 00:02: expiry, blink sequence 0->1->0, auto return on the third alarm tick.
        step(0, 0, 1, 0, 0, 0, 2);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(20);
        settle();
        check("t2_exp_blink0", dut_vec(), {16'h0000, 3'b010});
        idle(10);
        settle();
        check("t2_blink1", dut_vec(), {16'h0000, 3'b011});
        idle(10);
        settle();
        check("t2_blink0", dut_vec(), {16'h0000, 3'b010});
        idle(10);
        settle();
        check("t2_idle", dut_vec(), 19'h0);

        // Pause keeps the partial second; resume ticks 6 cycles later.
        step(0, 0, 1, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(13);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(50);
        settle();
        check("t3_frozen", dut_vec(), {16'h0004, 3'b000});
        step(1, 0, 0, 0, 0, 0, 0);
        idle(5);
        settle();
        check("t3_resume_early", dut_vec(), {16'h0004, 3'b100});
        idle(1);
        settle();
        check("t3_resume_tick", dut_vec(), {16'h0003, 3'b100});
        idle(80);

        // Start at 00:00 is ignored; oversize presets clamp to 99:59.
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        settle();
        check("t4_start_zero", dut_vec(), 19'h0);
        step(0, 0, 1, 9, 9, 7, 15);
        settle();
        check("t4_clamp", dut_vec(), {16'h9959, 3'b000});

        // Pause on the final tick loses to expiry; load+start together only loads.
        step(0, 0, 1, 0, 0, 0, 2);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(19);
        step(0, 1, 0, 0, 0, 0, 0);
        settle();
        check("t5_exp_wins", dut_vec(), {16'h0000, 3'b010});
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 3);
        settle();
        check("t5_load_wins", dut_vec(), {16'h0003, 3'b000});

        // Asynchronous reset mid-run, then start is ignored until a load.
        step(1, 0, 0, 0, 0, 0, 0);
        idle(5);
        settle();
        check("t6_running", dut_vec(), {16'h0003, 3'b100});
        @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b0;
        #1 check("t6_async_reset", dut_vec(), 19'h0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        settle();
        check("t6_start_ignored", dut_vec(), 19'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit s, p, l;
            int a, b, c, d;
            s = ($urandom_range(0, 15) == 0);
            p = ($urandom_range(0, 23) == 0);
            l = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom_range(0, 15); b = $urandom_range(0, 15);
            end else begin
                a = 0; b = 0;
            end
            c = $urandom_range(0, 7);
            d = $urandom_range(0, 15);
            step(s, p, l, a, b, c, d);
        end
        idle(1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: got %0d entries left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
